// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared definitions for the program loader and the decode-side checker:
// instruction field widths, bit positions inside the 32-bit instruction word,
// the loader state enum and the field-to-word pack function.
package program_loader_pkg;

   localparam int ICODE_W = 4;
   localparam int IFUN_W  = 4;
   localparam int REG_W   = 4;
   localparam int VALC_W  = 16;
   localparam int WORD_W  = 32;

   localparam int ICODE_MSB = 31;
   localparam int IFUN_MSB  = 27;
   localparam int RA_MSB    = 23;
   localparam int RB_MSB    = 19;
   localparam int VALC_MSB  = 15;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_HANDOFF = 2'd2,
      ST_RUN     = 2'd3
   } state_e;

   // Single definition of the instruction layout, shared by loader and decoder.
   function automatic logic [WORD_W-1:0] pack_insn(
      input logic [ICODE_W-1:0] icode,
      input logic [IFUN_W-1:0]  ifun,
      input logic [REG_W-1:0]   ra,
      input logic [REG_W-1:0]   rb,
      input logic [VALC_W-1:0]  valc
   );
      logic [WORD_W-1:0] w;
      w = '0;
      w[ICODE_MSB -: ICODE_W] = icode;
      w[IFUN_MSB  -: IFUN_W]  = ifun;
      w[RA_MSB    -: REG_W]   = ra;
      w[RB_MSB    -: REG_W]   = rb;
      w[VALC_MSB  -: VALC_W]  = valc;
      return w;
   endfunction

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if
// Instruction-field stream into the loader (valid/ready handshake).
//   in_valid                       : source has fields this cycle
//   in_ready                       : loader accepts fields this cycle
//   in_icode/in_ifun/in_rA/in_rB   : 4-bit instruction fields
//   in_valC                        : 16-bit constant field
//   in_last                        : marks the final instruction of the program
// master = field source, slave = loader.
interface program_loader_if;
   import program_loader_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [ICODE_W-1:0]   in_icode;
   logic [IFUN_W-1:0]    in_ifun;
   logic [REG_W-1:0]     in_rA;
   logic [REG_W-1:0]     in_rB;
   logic [VALC_W-1:0]    in_valC;
   logic                 in_last;

   modport master (
      output in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC, in_last,
      output in_ready
   );

endinterface

// File: rtl/program_loader_insn_pack.sv
// insn_pack
// Combinational field-to-word packer, reusable by the decode-side checker.
//   icode_i, ifun_i, ra_i, rb_i : 4-bit fields
//   valc_i                      : 16-bit constant
//   word_o                      : packed 32-bit instruction word
module insn_pack
   import program_loader_pkg::*;
(
   input  logic [ICODE_W-1:0] icode_i,
   input  logic [IFUN_W-1:0]  ifun_i,
   input  logic [REG_W-1:0]   ra_i,
   input  logic [REG_W-1:0]   rb_i,
   input  logic [VALC_W-1:0]  valc_i,
   output logic [WORD_W-1:0]  word_o
);

   assign word_o = pack_insn(icode_i, ifun_i, ra_i, rb_i, valc_i);

endmodule

// File: rtl/program_loader.sv
// program_loader
// Accepts decoded instruction fields, packs them and writes them to the
// processor's program RAM at consecutive addresses from BASE_ADDR, then
// waits HANDOFF_DELAY cycles and raises `working` to hand the RAM to fetch.
//   clock, reset : sole clock (rising edge), synchronous active-high reset
//   start        : one-cycle pulse opening a load session (IDLE or RUN only)
//   in_if        : field stream (slave side)
//   addr/wr/wdata: registered RAM write port
//   working      : fetch enable
//   count        : words written in the current or last session
//   overflow     : sticky, RAM filled before in_last arrived
module program_loader
   import program_loader_pkg::*;
#(
   parameter logic [8:0]  BASE_ADDR     = 9'd0,
   parameter int unsigned DEPTH         = 512,
   parameter int unsigned HANDOFF_DELAY = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   program_loader_if.slave    in_if,
   output logic [8:0]         addr,
   output logic               wr,
   output logic [WORD_W-1:0]  wdata,
   output logic               working,
   output logic [9:0]         count,
   output logic               overflow
);

   localparam logic [8:0] LAST_ADDR = 9'(DEPTH - 1);
   // Counter is loaded with DELAY-1 so HANDOFF lasts exactly DELAY cycles.
   localparam logic [3:0] HOLD_INIT = 4'(HANDOFF_DELAY - 1);

   state_e              state_q, state_d;
   logic [8:0]          ptr_q, ptr_d;
   logic [8:0]          addr_q, addr_d;
   logic                wr_q, wr_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic [9:0]          count_q, count_d;
   logic                overflow_q, overflow_d;
   logic [3:0]          hcnt_q, hcnt_d;

   logic                ready;
   logic                xfer;
   logic                at_end;
   logic [WORD_W-1:0]   packed_word;

   insn_pack u_pack (
      .icode_i (in_if.in_icode),
      .ifun_i  (in_if.in_ifun),
      .ra_i    (in_if.in_rA),
      .rb_i    (in_if.in_rB),
      .valc_i  (in_if.in_valC),
      .word_o  (packed_word)
   );

   assign xfer   = in_if.in_valid & ready;
   assign at_end = (ptr_q == LAST_ADDR);

   // State and datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ptr_q      <= BASE_ADDR;
         addr_q     <= '0;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         hcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         addr_q     <= addr_d;
         wr_q       <= wr_d;
         wdata_q    <= wdata_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         hcnt_q     <= hcnt_d;
      end
   end

   // Next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_RUN: if (start) state_d = ST_LOAD;
         // The last RAM word ends the session even without in_last.
         ST_LOAD:         if (xfer && (in_if.in_last || at_end)) state_d = ST_HANDOFF;
         ST_HANDOFF:      if (hcnt_q == 4'd0) state_d = ST_RUN;
         default:         state_d = ST_IDLE;
      endcase
   end

   // Datapath next values.
   always_comb begin
      ptr_d      = ptr_q;
      addr_d     = addr_q;
      wr_d       = 1'b0;
      wdata_d    = wdata_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      hcnt_d     = hcnt_q;
      case (state_q)
         ST_IDLE, ST_RUN: begin
            if (start) begin
               ptr_d      = BASE_ADDR;
               count_d    = '0;
               overflow_d = 1'b0;
            end
         end
         ST_LOAD: begin
            if (xfer) begin
               addr_d     = ptr_q;
               wdata_d    = packed_word;
               wr_d       = 1'b1;
               count_d    = count_q + 10'd1;
               // Hold at the last word instead of wrapping; the session ends here.
               ptr_d      = at_end ? ptr_q : ptr_q + 9'd1;
               overflow_d = at_end & ~in_if.in_last;
               hcnt_d     = HOLD_INIT;
            end
         end
         ST_HANDOFF: begin
            if (hcnt_q != 4'd0) hcnt_d = hcnt_q - 4'd1;
         end
         default: ;
      endcase
   end

   // Outputs decoded from state.
   always_comb begin
      ready   = (state_q == ST_LOAD);
      working = (state_q == ST_RUN);
   end

   assign in_if.in_ready = ready;
   assign addr           = addr_q;
   assign wr             = wr_q;
   assign wdata          = wdata_q;
   assign count          = count_q;
   assign overflow       = overflow_q;

endmodule
